// File: rtl/wav_header_parser.sv
// rtl/wav_header_parser.sv - on-the-fly RIFF/WAVE header parser for the ioctl download stream
// Publishes PCM format fields and the DDRAM location/length of the 'data' payload.
module wav_header_parser #(
  parameter int ADDR_W  = 25,
  parameter int MAX_HDR = 4096
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              busy,
  output logic              hdr_valid,
  output logic              hdr_error,
  output logic [2:0]        err_code,
  output logic [15:0]       num_channels,
  output logic [31:0]       sample_rate,
  output logic [15:0]       bits_per_sample,
  output logic [15:0]       block_align,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_len
);

  typedef enum logic [3:0] {
    IDLE, RIFF_ID, RIFF_SIZE, WAVE_ID, CK_ID, CK_SIZE, FMT_BODY, SKIP, DONE, ERR
  } state_t;

  localparam logic [2:0] E_RIFF = 3'd1, E_WAVE = 3'd2, E_FMT = 3'd3, E_NOFMT = 3'd4;
  localparam logic [2:0] E_TRUNC = 3'd5, E_LONG = 3'd6, E_GAP = 3'd7;
  // Tags stored little-endian so byte lane n holds the n-th character.
  localparam logic [31:0] TAG_RIFF = 32'h4646_4952;
  localparam logic [31:0] TAG_WAVE = 32'h4556_4157;
  localparam logic [31:0] ID_FMT   = 32'h2074_6d66;
  localparam logic [31:0] ID_DATA  = 32'h6174_6164;

  state_t            state;
  logic              act_q;
  logic [ADDR_W-1:0] exp_addr;
  logic [1:0]        cnt;
  logic [3:0]        off;
  logic [31:0]       ck_id;
  logic [31:0]       sz;
  logic [32:0]       skip;
  logic [7:0]        fmt_lo;
  logic              fmt_seen;

  logic        rise, fall, parsing, consume, last;
  logic        bad, accept;
  logic [2:0]  bad_code;
  logic [7:0]  tag_byte;
  logic [31:0] sz_full;
  logic [32:0] skip_chunk, skip_fmt;

  assign rise       = dl_active & ~act_q;
  assign fall       = ~dl_active & act_q;
  assign parsing    = state inside {RIFF_ID, RIFF_SIZE, WAVE_ID, CK_ID, CK_SIZE, FMT_BODY, SKIP};
  assign consume    = dl_wr & parsing & ~rise;
  assign last       = (cnt == 2'd3);
  assign sz_full    = {dl_data, sz[23:0]};
  assign skip_chunk = {1'b0, sz_full} + {32'd0, sz_full[0]};
  assign skip_fmt   = {1'b0, sz - 32'd16} + {32'd0, sz[0]};

  // Verdict on the byte currently presented; only acted on when it is consumed.
  always_comb begin
    bad      = 1'b0;
    bad_code = 3'd0;
    accept   = 1'b0;
    tag_byte = (state == WAVE_ID) ? TAG_WAVE[{cnt, 3'b000} +: 8] : TAG_RIFF[{cnt, 3'b000} +: 8];
    if (dl_addr != exp_addr) begin
      bad      = 1'b1;
      bad_code = E_GAP;
    end else if (dl_addr >= ADDR_W'(MAX_HDR)) begin
      bad      = 1'b1;
      bad_code = E_LONG;
    end else begin
      case (state)
        RIFF_ID: if (dl_data != tag_byte) begin
          bad      = 1'b1;
          bad_code = E_RIFF;
        end
        WAVE_ID: if (dl_data != tag_byte) begin
          bad      = 1'b1;
          bad_code = E_WAVE;
        end
        CK_SIZE: if (last) begin
          if (ck_id == ID_FMT && sz_full < 32'd16) begin
            bad      = 1'b1;
            bad_code = E_FMT;
          end else if (ck_id == ID_DATA) begin
            if (!fmt_seen) begin
              bad      = 1'b1;
              bad_code = E_NOFMT;
            end else begin
              accept = 1'b1;
            end
          end
        end
        FMT_BODY: if (off == 4'd1 && {dl_data, fmt_lo} != 16'd1) begin
          bad      = 1'b1;
          bad_code = E_FMT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    // Reset samples dl_active so a download already in flight is ignored, not restarted.
    act_q <= dl_active;
    if (reset || rise) begin
      state           <= reset ? IDLE : RIFF_ID;
      busy            <= ~reset;
      hdr_valid       <= 1'b0;
      hdr_error       <= 1'b0;
      err_code        <= 3'd0;
      num_channels    <= 16'd0;
      sample_rate     <= 32'd0;
      bits_per_sample <= 16'd0;
      block_align     <= 16'd0;
      data_addr       <= '0;
      data_len        <= 32'd0;
      exp_addr        <= '0;
      cnt             <= 2'd0;
      off             <= 4'd0;
      ck_id           <= 32'd0;
      sz              <= 32'd0;
      skip            <= 33'd0;
      fmt_lo          <= 8'd0;
      fmt_seen        <= 1'b0;
    end else begin
      if (consume) begin
        exp_addr <= exp_addr + 1'b1;
        if (bad) begin
          state     <= ERR;
          hdr_error <= 1'b1;
          busy      <= 1'b0;
          err_code  <= bad_code;
        end else begin
          case (state)
            RIFF_ID: begin
              cnt <= cnt + 1'b1;
              if (last) state <= RIFF_SIZE;
            end
            RIFF_SIZE: begin
              cnt <= cnt + 1'b1;
              if (last) state <= WAVE_ID;
            end
            WAVE_ID: begin
              cnt <= cnt + 1'b1;
              if (last) state <= CK_ID;
            end
            CK_ID: begin
              ck_id[{cnt, 3'b000} +: 8] <= dl_data;
              cnt <= cnt + 1'b1;
              if (last) state <= CK_SIZE;
            end
            CK_SIZE: begin
              sz[{cnt, 3'b000} +: 8] <= dl_data;
              cnt <= cnt + 1'b1;
              if (last) begin
                if (ck_id == ID_FMT) begin
                  off   <= 4'd0;
                  state <= FMT_BODY;
                end else if (accept) begin
                  data_addr <= exp_addr + 1'b1;
                  data_len  <= sz_full;
                  hdr_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= DONE;
                end else begin
                  skip  <= skip_chunk;
                  state <= (skip_chunk == 33'd0) ? CK_ID : SKIP;
                end
              end
            end
            FMT_BODY: begin
              off <= off + 1'b1;
              case (off)
                4'd0:  fmt_lo                <= dl_data;
                4'd2:  num_channels[7:0]     <= dl_data;
                4'd3:  num_channels[15:8]    <= dl_data;
                4'd4:  sample_rate[7:0]      <= dl_data;
                4'd5:  sample_rate[15:8]     <= dl_data;
                4'd6:  sample_rate[23:16]    <= dl_data;
                4'd7:  sample_rate[31:24]    <= dl_data;
                4'd12: block_align[7:0]      <= dl_data;
                4'd13: block_align[15:8]     <= dl_data;
                4'd14: bits_per_sample[7:0]  <= dl_data;
                4'd15: begin
                  bits_per_sample[15:8] <= dl_data;
                  fmt_seen              <= 1'b1;
                  skip                  <= skip_fmt;
                  state                 <= (skip_fmt == 33'd0) ? CK_ID : SKIP;
                end
                default: ;
              endcase
            end
            SKIP: begin
              skip <= skip - 33'd1;
              if (skip == 33'd1) state <= CK_ID;
            end
            default: ;
          endcase
        end
      end
      // A final byte that concludes the parse outranks the truncation it arrives with.
      if (fall && busy && !(consume && (bad || accept))) begin
        state     <= ERR;
        hdr_error <= 1'b1;
        busy      <= 1'b0;
        err_code  <= E_TRUNC;
      end
    end
  end

endmodule

// File: tb/tb_wav_header_parser.sv
// tb/tb_wav_header_parser.sv - self-checking bench for wav_header_parser
module tb_wav_header_parser;
  localparam int AW = 25;

  logic          clk_sys = 1'b0;
  logic          reset, dl_active, dl_wr;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_data;
  logic          busy, hdr_valid, hdr_error;
  logic [2:0]    err_code;
  logic [15:0]   num_channels, bits_per_sample, block_align;
  logic [31:0]   sample_rate, data_len;
  logic [AW-1:0] data_addr;

  always #5 clk_sys = ~clk_sys;

  wav_header_parser #(.ADDR_W(AW), .MAX_HDR(4096)) dut (
    .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .busy(busy), .hdr_valid(hdr_valid),
    .hdr_error(hdr_error), .err_code(err_code), .num_channels(num_channels),
    .sample_rate(sample_rate), .bits_per_sample(bits_per_sample),
    .block_align(block_align), .data_addr(data_addr), .data_len(data_len)
  );

  typedef struct {
    int scen; int gap; bit fall_last; bit valid; int code; int daddr; int dlen;
  } vec_t;

  typedef struct {
    bit valid; bit err; int code; longint pos;
    longint daddr, dlen, nch, rate, bits, balign;
  } res_t;

  int         total = 0;
  int         nbad  = 0;
  logic [7:0] fq[$];
  int         aq[$];
  logic       v_before, v_at, busy_first;

  task automatic chk(input string nm, input longint act, input longint want);
    total++;
    if (act != want) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic p8(input int v);   fq.push_back(v[7:0]); endtask
  task automatic p16(input int v);  p8(v); p8(v >> 8); endtask
  task automatic p32(input int v);  p16(v); p16(v >> 16); endtask
  task automatic ptag(input string s);
    for (int i = 0; i < 4; i++) p8(int'(s[i]));
  endtask

  task automatic pfmt(input int size, input int af, input int nch, input int rate,
                      input int ba, input int bits);
    ptag("fmt "); p32(size); p16(af); p16(nch); p32(rate); p32(rate * ba); p16(ba); p16(bits);
    for (int i = 16; i < size + (size & 1); i++) p8(0);
  endtask

  task automatic canon;
    ptag("RIFF"); p32(36 + 65536); ptag("WAVE");
    pfmt(16, 1, 2, 44100, 4, 16);
    ptag("data"); p32(32'h10000);
  endtask

  task automatic build(input int scen);
    fq.delete(); aq.delete();
    case (scen)
      0: canon();
      1: begin
        ptag("RIFF"); p32(0); ptag("WAVE");
        pfmt(18, 1, 1, 22050, 2, 16);
        ptag("LIST"); p32(27);
        for (int i = 0; i < 28; i++) p8(i);
        ptag("data"); p32(100);
      end
      2: begin canon(); fq[11] = 8'h58; end
      3: begin
        ptag("RIFF"); p32(0); ptag("WAVE");
        pfmt(16, 3, 2, 48000, 8, 32);
        ptag("data"); p32(64);
      end
      4: begin
        ptag("RIFF"); p32(0); ptag("WAVE");
        ptag("data"); p32(8); p32(0); p32(0);
        pfmt(16, 1, 2, 44100, 4, 16);
      end
      5: begin canon(); while (fq.size() > 31) void'(fq.pop_back()); end
      6: canon();
      7: begin
        ptag("RIFF"); p32(0); ptag("WAVE");
        pfmt(16, 1, 2, 44100, 4, 16);
        ptag("junk"); p32(5000);
        for (int i = 0; i < 5000; i++) p8(i);
        ptag("data"); p32(4);
      end
      9: begin canon(); fq[3] = 8'h58; end
      10: begin ptag("RIFF"); p32(0); ptag("WAVE"); pfmt(14, 1, 2, 8000, 4, 16); end
      default: canon();
    endcase
    for (int i = 0; i < fq.size(); i++) aq.push_back(i);
    if (scen == 6) for (int i = 20; i < aq.size(); i++) aq[i] = i + 1;
  endtask

  task automatic send(input int gap, input bit fall_last);
    dl_active = 1'b1; dl_wr = 1'b0;
    tick;
    busy_first = busy;
    for (int i = 0; i < fq.size(); i++) begin
      dl_wr = 1'b1; dl_addr = AW'(aq[i]); dl_data = fq[i];
      if (i == fq.size() - 1 && fall_last) dl_active = 1'b0;
      tick;
      dl_wr = 1'b0;
      if (i == fq.size() - 2) v_before = hdr_valid;
      if (i == fq.size() - 1) v_at = hdr_valid;
      repeat (gap) tick;
    end
    dl_active = 1'b0;
    tick; tick;
  endtask

  function automatic bit is_tag(input longint p, input string t);
    return fq[p] == t[0] && fq[p+1] == t[1] && fq[p+2] == t[2] && fq[p+3] == t[3];
  endfunction

  // Chunk walk over the byte stream as a whole file, ignoring addresses.
  function automatic res_t walk();
    res_t r; longint p, n; logic [31:0] sz; bit fseen; string t1, t2;
    t1 = "RIFF"; t2 = "WAVE";
    n = fq.size();
    r = '{default: 0};
    r.err = 1; r.code = 5; r.pos = n;
    for (int k = 0; k < 4; k++) begin
      if (k >= n) return r;
      if (fq[k] != t1[k]) begin r.code = 1; r.pos = k; return r; end
    end
    for (int k = 0; k < 4; k++) begin
      if (k + 8 >= n) return r;
      if (fq[k+8] != t2[k]) begin r.code = 2; r.pos = k + 8; return r; end
    end
    p = 12; fseen = 0;
    for (int it = 0; it < 1000; it++) begin
      if (p + 7 >= n) return r;
      sz = {fq[p+7], fq[p+6], fq[p+5], fq[p+4]};
      if (is_tag(p, "fmt ")) begin
        p += 8;
        if (sz < 16) begin r.code = 3; r.pos = p - 1; return r; end
        if (p + 1 >= n) return r;
        if ({fq[p+1], fq[p]} != 16'd1) begin r.code = 3; r.pos = p + 1; return r; end
        if (p + 15 >= n) return r;
        r.nch    = {fq[p+3], fq[p+2]};
        r.rate   = {fq[p+7], fq[p+6], fq[p+5], fq[p+4]};
        r.balign = {fq[p+13], fq[p+12]};
        r.bits   = {fq[p+15], fq[p+14]};
        fseen = 1;
        p += longint'(sz) + longint'(sz[0]);
      end else if (is_tag(p, "data")) begin
        p += 8;
        if (!fseen) begin r.code = 4; r.pos = p - 1; return r; end
        r.valid = 1; r.err = 0; r.code = 0; r.pos = p - 1;
        r.daddr = p; r.dlen = longint'(sz);
        return r;
      end else begin
        p += 8 + longint'(sz) + longint'(sz[0]);
      end
    end
    return r;
  endfunction

  function automatic res_t model();
    res_t r;
    r = walk();
    for (int i = 0; i < aq.size(); i++) begin
      if (aq[i] != i || aq[i] >= 4096) begin
        if (i <= r.pos) begin
          r.valid = 0; r.err = 1; r.code = (aq[i] != i) ? 7 : 6;
        end
        break;
      end
    end
    return r;
  endfunction

  task automatic gen_random;
    int n, sz;
    fq.delete(); aq.delete();
    ptag("RIFF"); p32($urandom); ptag("WAVE");
    if ($urandom_range(0, 7) == 0) begin ptag("data"); p32(4); p32(0); end
    n = $urandom_range(0, 2);
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < 4; k++) p8(97 + $urandom_range(0, 25));
      sz = $urandom_range(0, 21);
      p32(sz);
      for (int i = 0; i < sz + (sz & 1); i++) p8($urandom);
    end
    pfmt($urandom_range(16, 21), ($urandom_range(0, 7) == 0) ? 3 : 1, $urandom_range(1, 8),
         $urandom_range(8000, 96000), $urandom_range(1, 8), 8 * $urandom_range(1, 4));
    if ($urandom_range(0, 1) == 0) begin
      ptag("cue "); sz = $urandom_range(0, 9); p32(sz);
      for (int i = 0; i < sz + (sz & 1); i++) p8($urandom);
    end
    ptag("data"); p32($urandom);
    if ($urandom_range(0, 5) == 0) fq[$urandom_range(0, fq.size() - 1)] = 8'($urandom);
    if ($urandom_range(0, 7) == 0) begin
      n = $urandom_range(1, fq.size() - 1);
      while (fq.size() > n) void'(fq.pop_back());
    end
    for (int i = 0; i < fq.size(); i++) aq.push_back(i);
    if ($urandom_range(0, 7) == 0) begin
      n = $urandom_range(0, aq.size() - 1);
      aq[n] = aq[n] + $urandom_range(1, 3);
    end
  endtask

  vec_t vt[12];
  res_t e;

  initial begin
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = 8'd0;
    tick; tick;
    reset = 1'b0;
    tick;
    chk("rst.busy", busy, 0);            chk("rst.valid", hdr_valid, 0);
    chk("rst.error", hdr_error, 0);      chk("rst.code", err_code, 0);
    chk("rst.nch", num_channels, 0);     chk("rst.rate", sample_rate, 0);
    chk("rst.bits", bits_per_sample, 0); chk("rst.balign", block_align, 0);
    chk("rst.daddr", data_addr, 0);      chk("rst.dlen", data_len, 0);

    vt = '{
      '{0, 0, 0, 1, 0, 44, 65536},
      '{2, 0, 0, 0, 2, 0, 0},
      '{1, 3, 0, 1, 0, 82, 100},
      '{3, 0, 0, 0, 3, 0, 0},
      '{4, 0, 0, 0, 4, 0, 0},
      '{5, 0, 0, 0, 5, 0, 0},
      '{5, 0, 1, 0, 5, 0, 0},
      '{6, 0, 0, 0, 7, 0, 0},
      '{7, 0, 0, 0, 6, 0, 0},
      '{0, 0, 1, 1, 0, 44, 65536},
      '{9, 0, 0, 0, 1, 0, 0},
      '{10, 1, 0, 0, 3, 0, 0}
    };
    foreach (vt[k]) begin
      build(vt[k].scen);
      send(vt[k].gap, vt[k].fall_last);
      chk($sformatf("vec%0d.busy_start", k), busy_first, 1);
      chk($sformatf("vec%0d.valid", k), hdr_valid, vt[k].valid);
      chk($sformatf("vec%0d.error", k), hdr_error, !vt[k].valid);
      chk($sformatf("vec%0d.code", k), err_code, vt[k].code);
      chk($sformatf("vec%0d.busy", k), busy, 0);
      chk($sformatf("vec%0d.daddr", k), data_addr, vt[k].daddr);
      chk($sformatf("vec%0d.dlen", k), data_len, vt[k].dlen);
      if (vt[k].valid) begin
        chk($sformatf("vec%0d.valid_early", k), v_before, 0);
        chk($sformatf("vec%0d.valid_latency", k), v_at, 1);
      end
    end

    build(0);
    send(0, 0);
    chk("canon.nch", num_channels, 2);
    chk("canon.rate", sample_rate, 44100);
    chk("canon.bits", bits_per_sample, 16);
    chk("canon.balign", block_align, 4);

    // Reset pulse mid-download at addr 20; the rest of the stream must be ignored.
    build(0);
    dl_active = 1'b1;
    tick;
    for (int i = 0; i < fq.size(); i++) begin
      dl_wr = 1'b1; dl_addr = AW'(aq[i]); dl_data = fq[i];
      if (i == 20) reset = 1'b1;
      tick;
      reset = 1'b0; dl_wr = 1'b0;
      if (i == 19) chk("rstmid.busy_before", busy, 1);
      if (i == 20) begin
        chk("rstmid.busy", busy, 0);
        chk("rstmid.valid", hdr_valid, 0);
        chk("rstmid.error", hdr_error, 0);
        chk("rstmid.code", err_code, 0);
      end
    end
    chk("rstmid.after_busy", busy, 0);
    chk("rstmid.after_valid", hdr_valid, 0);
    chk("rstmid.after_error", hdr_error, 0);
    chk("rstmid.after_nch", num_channels, 0);
    chk("rstmid.after_daddr", data_addr, 0);
    dl_active = 1'b0;
    tick; tick;
    build(0);
    send(0, 0);
    chk("restart.valid", hdr_valid, 1);
    chk("restart.daddr", data_addr, 44);

    for (int it = 0; it < 60; it++) begin
      gen_random();
      e = model();
      send($urandom_range(0, 1), $urandom_range(0, 3) == 0);
      chk($sformatf("rnd%0d.valid", it), hdr_valid, e.valid);
      chk($sformatf("rnd%0d.error", it), hdr_error, e.err);
      chk($sformatf("rnd%0d.code", it), err_code, e.code);
      chk($sformatf("rnd%0d.busy", it), busy, 0);
      if (e.valid) begin
        chk($sformatf("rnd%0d.daddr", it), data_addr, e.daddr);
        chk($sformatf("rnd%0d.dlen", it), data_len, e.dlen);
        chk($sformatf("rnd%0d.nch", it), num_channels, e.nch);
        chk($sformatf("rnd%0d.rate", it), sample_rate, e.rate);
        chk($sformatf("rnd%0d.bits", it), bits_per_sample, e.bits);
        chk($sformatf("rnd%0d.balign", it), block_align, e.balign);
      end
    end

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule

// File: doc/wav_header_parser.md
Name: wav_header_parser

Overview:
- Snoops the HPS ioctl byte stream while a .wav file (ioctl_index 1) is written to DDRAM and parses the RIFF/WAVE header on the fly.
- Publishes the format fields and the DDRAM byte address and length of the PCM payload.
- wave_sound uses these to set its start address, end-of-sample bound and rate step, and skips header bytes instead of playing them.
- Passive: consumes one byte per cycle, never asserts ioctl_wait.

Parameters:
- ADDR_W, 25, width of the download byte address (matches ioctl_addr).
- MAX_HDR, 4096, byte address by which the 'data' chunk body must start, else error.

Ports:
- clk_sys  in  1  system clock (24 MHz).
- reset  in  1  synchronous, active-high reset.
- dl_active  in  1  ioctl_download & wav_load.
- dl_wr  in  1  byte strobe (ioctl_wr & wav_load), one cycle per byte.
- dl_addr  in  ADDR_W  byte address of dl_data.
- dl_data  in  8  download byte.
- busy  out  1  parse in progress.
- hdr_valid  out  1  header accepted, fields stable.
- hdr_error  out  1  header rejected.
- err_code  out  3  reason; 0 when no error.
- num_channels  out  16  from fmt.
- sample_rate  out  32  from fmt, in Hz.
- bits_per_sample  out  16  from fmt.
- block_align  out  16  from fmt.
- data_addr  out  ADDR_W  address of the first payload byte.
- data_len  out  32  payload size in bytes, from the 'data' chunk size.

Behaviour:
- Reset: all outputs 0, state IDLE, fmt_seen=0.
- A dl_active rising edge (registered previous value) clears every output and the fmt_seen flag, sets busy=1, expected address exp=0, and enters RIFF_ID. This happens in any state.
- A byte is consumed only on cycles with dl_wr=1 in a parsing state. Each consumed byte increments exp. In IDLE, DONE and ERR, dl_wr is ignored.
- All multi-byte fields are little-endian. A field byte counter (0..3) selects the byte lane.
- If dl_addr != exp on a consumed byte: ERR, code 7 (ADDR_GAP).
- States and transitions:
  - RIFF_ID: 4 bytes must equal "RIFF", else code 1 (BAD_RIFF) at the first mismatching byte.
  - RIFF_SIZE: 4 bytes, value ignored.
  - WAVE_ID: must equal "WAVE", else code 2 (BAD_WAVE).
  - CK_ID: capture 4-byte chunk id.
  - CK_SIZE: capture 32-bit size (sz). On its last byte:
    - id "fmt ": if sz<16, code 3; else go to FMT_BODY.
    - id "data": if fmt_seen=0, code 4 (NO_FMT); else set data_addr=exp+1 (address following this byte), data_len=sz, hdr_valid=1, busy=0, and go to DONE.
    - any other id: load skip=sz+sz[0]. If skip==0 go to CK_ID, else go to SKIP.
  - FMT_BODY: 16 bytes at offsets 0-1 audio_format, 2-3 channels, 4-7 rate, 8-11 byte_rate (ignored), 12-13 block_align, 14-15 bits.
    - audio_format != 1: code 3 (NOT_PCM) after offset 1.
    - After offset 15: set fmt_seen. Load skip=(sz-16)+sz[0]. If skip==0 go to CK_ID, else go to SKIP.
  - SKIP: decrement skip per consumed byte; at 1 -> 0 go to CK_ID. The skip counter is 33 bits, so a size of 0xFFFFFFFF does not wrap.
- TOO_LONG: in any parsing state, a consumed byte with dl_addr >= MAX_HDR gives code 6. This has priority below code 7.
- TRUNC: a dl_active falling edge while busy gives code 5, even when it coincides with a final dl_wr; that byte is processed first, and its result takes priority.
- On entering ERR: hdr_error=1, busy=0, err_code latched, format fields hold whatever was captured.
- DONE and ERR hold until reset or the next dl_active rise.
- Output latency: an output register updates on the clock edge that samples the relevant byte, so it is visible the next cycle. hdr_valid and hdr_error are never both 1.
- Reset mid-parse returns to IDLE with all outputs 0. A subsequent dl_active rise restarts cleanly.

Test Plan:
- Canonical 44-byte header (fmt size 16, PCM, 2 ch, 44100, block_align 4, 16 bit, data size 0x00010000), 1 byte/cycle -> hdr_valid=1 the cycle after addr 43; data_addr=44, data_len=65536, sample_rate=44100, num_channels=2, bits=16, busy=0.
- Header with fmt size 18 plus a "LIST" chunk of size 0x1B before "data", bytes spaced 3 idle cycles apart -> pad byte skipped; data_addr=12+26+8+28+8=82, hdr_valid=1, err_code=0.
- Bytes 8-11 = "WAVX" -> hdr_error=1, err_code=2 after addr 11; further bytes ignored; next dl_active rise with a valid file -> hdr_valid=1.
- fmt audio_format=3 -> err_code=3; a "data" chunk before any fmt -> err_code=4; dl_active drops after addr 30 -> err_code=5.
- Address jump 19 -> 21 -> err_code=7. A 5000-byte "junk" chunk pushing "data" past 4096 -> err_code=6.
- reset asserted for 1 cycle at addr 20 -> all outputs 0 the next cycle, state IDLE, remaining bytes ignored.
